// File: rtl/pattern_tx_if.sv
// Handshake and serial-output bundle for the 1101-preamble frame transmitter.
// The master side supplies words; the slave side (the transmitter) drives the link.
interface pattern_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  in_ready;
  logic                  serial_out;
  logic                  busy;
  logic                  tx_done;

  modport master (
    output in_valid, data_in,
    input  in_ready, serial_out, busy, tx_done
  );

  modport slave (
    input  in_valid, data_in,
    output in_ready, serial_out, busy, tx_done
  );
endinterface

// File: rtl/pattern_tx.sv
// Serial frame transmitter: preamble, then the payload MSB-first. Optional bit
// stuffing stops the preamble pattern from appearing inside the payload.
module pattern_tx #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [3:0] PREAMBLE   = 4'b1101,
  parameter bit         STUFF_EN   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  pattern_tx_if.slave  bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, PRE, DATA, STUFF} state_t;

  state_t                state_reg,   state_next;
  logic [DATA_WIDTH-1:0] shift_reg,   shift_next;
  logic [CW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [1:0]            pre_cnt_reg, pre_cnt_next;
  logic [2:0]            hist_reg,    hist_next;
  logic                  serial_reg,  serial_next;
  logic                  done_reg,    done_next;
  logic                  emit;
  logic                  pre_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      pre_cnt_reg <= '0;
      hist_reg    <= '0;
      serial_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      pre_cnt_reg <= pre_cnt_next;
      hist_reg    <= hist_next;
      serial_reg  <= serial_next;
      done_reg    <= done_next;
    end
  end

  // serial_reg always holds the bit currently on the line; hist_reg tracks the
  // last three bits put there, so each edge decides the bit for the next cycle.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    pre_cnt_next = pre_cnt_reg;
    hist_next    = hist_reg;
    serial_next  = 1'b0;
    done_next    = 1'b0;
    emit         = 1'b0;
    pre_bit      = PREAMBLE[2'd2 - pre_cnt_reg];

    case (state_reg)
      IDLE: begin
        hist_next = '0;
        if (bus.in_valid) begin
          state_next   = PRE;
          shift_next   = bus.data_in;
          bit_cnt_next = '0;
          pre_cnt_next = '0;
          serial_next  = PREAMBLE[3];
          hist_next    = {2'b00, PREAMBLE[3]};
        end
      end
      PRE: begin
        if (pre_cnt_reg == 2'd3) begin
          emit = 1'b1;
        end else begin
          pre_cnt_next = pre_cnt_reg + 2'd1;
          serial_next  = pre_bit;
          hist_next    = {hist_reg[1:0], pre_bit};
        end
      end
      DATA: begin
        if (bit_cnt_reg == LAST_CNT) begin
          state_next = IDLE;
          done_next  = 1'b1;
          hist_next  = '0;
        end else begin
          emit = 1'b1;
        end
      end
      STUFF: emit = 1'b1;
      default: state_next = IDLE;
    endcase

    // A stuff bit leaves the pending payload bit in place and resets hist to x00,
    // so it can never be followed directly by another stuff bit.
    if (emit) begin
      if (STUFF_EN && hist_reg == 3'b110 && shift_reg[DATA_WIDTH-1]) begin
        state_next  = STUFF;
        serial_next = 1'b0;
        hist_next   = {hist_reg[1:0], 1'b0};
      end else begin
        state_next   = DATA;
        serial_next  = shift_reg[DATA_WIDTH-1];
        shift_next   = shift_reg << 1;
        bit_cnt_next = bit_cnt_reg + CW'(1);
        hist_next    = {hist_reg[1:0], shift_reg[DATA_WIDTH-1]};
      end
    end
  end

  assign bus.in_ready   = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.serial_out = serial_reg;
  assign bus.tx_done    = done_reg;
endmodule

// File: tb/tb_pattern_tx.sv
// Drives a stuffing and a non-stuffing transmitter with the same stimulus and
// compares every cycle against a frame-level model built from bit lists.
module tb_pattern_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] data_in = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  pattern_tx_if #(.DATA_WIDTH(8)) bus0 ();
  pattern_tx_if #(.DATA_WIDTH(8)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.data_in  = data_in;
  assign bus1.in_valid = in_valid;
  assign bus1.data_in  = data_in;

  pattern_tx #(.DATA_WIDTH(8), .PREAMBLE(4'b1101), .STUFF_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  pattern_tx #(.DATA_WIDTH(8), .PREAMBLE(4'b1101), .STUFF_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  // Model: per DUT, the full list of bits of the frame in flight.
  bit frm [2][32];
  int len [2];
  int pos [2];
  bit act [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build(input int d, input logic [7:0] w, input bit stuff);
    logic [3:0] pre;
    pre = 4'b1101;
    len[d] = 0;
    for (int i = 3; i >= 0; i--) begin
      frm[d][len[d]] = pre[i];
      len[d]++;
    end
    for (int i = 7; i >= 0; i--) begin
      if (stuff && w[i] && frm[d][len[d]-3] && frm[d][len[d]-2] && !frm[d][len[d]-1]) begin
        frm[d][len[d]] = 1'b0;
        len[d]++;
      end
      frm[d][len[d]] = w[i];
      len[d]++;
    end
  endtask

  task automatic check_outputs(input int d, input bit exp_ser, input bit exp_done,
                               input bit exp_rdy, input bit exp_busy);
    string s;
    s = (d == 0) ? "stuff" : "nostuff";
    chk({s, ".serial_out"}, (d == 0) ? bus0.serial_out : bus1.serial_out, 32'(exp_ser));
    chk({s, ".tx_done"},    (d == 0) ? bus0.tx_done    : bus1.tx_done,    32'(exp_done));
    chk({s, ".in_ready"},   (d == 0) ? bus0.in_ready   : bus1.in_ready,   32'(exp_rdy));
    chk({s, ".busy"},       (d == 0) ? bus0.busy       : bus1.busy,       32'(exp_busy));
  endtask

  // One clock: model reacts to the inputs present at the edge, then outputs are checked.
  task automatic cycle();
    bit ser [2];
    bit done [2];
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      ser[d]  = 1'b0;
      done[d] = 1'b0;
      if (rst) begin
        act[d] = 1'b0;
      end else if (act[d]) begin
        if (pos[d] < len[d]) begin
          ser[d] = frm[d][pos[d]];
          pos[d]++;
        end else begin
          act[d]  = 1'b0;
          done[d] = 1'b1;
        end
      end else if (in_valid) begin
        build(d, data_in, d == 0);
        ser[d] = frm[d][0];
        pos[d] = 1;
        act[d] = 1'b1;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d, ser[d], done[d], !act[d], act[d]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic frame(input logic [7:0] w);
    in_valid = 1'b1;
    data_in  = w;
    cycle();
    in_valid = 1'b0;
    data_in  = 8'($urandom);
  endtask

  task automatic async_reset_check();
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; len[d] = 0; pos[d] = 0;
    end
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_outputs(d, 1'b0, 1'b0, 1'b1, 1'b0);
    run(2);
    rst = 1'b0;
    run(2);

    frame(8'h00);  run(16);
    frame(8'hD0);  run(16);

    in_valid = 1'b1;
    data_in  = 8'hFF;
    run(26);
    in_valid = 1'b0;
    run(16);

    frame(8'hA5);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in  = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    run(16);

    frame(8'hB6);
    run(7);
    async_reset_check();
    run(2);
    frame(8'hD0);  run(16);

    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      data_in  = ($urandom_range(0, 3) == 0) ? 8'hDB : 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
